result_drain: RTL and testbench

- Sits directly downstream of the systolic array.
- Watches the array's sticky completion flag and snapshots its L parallel 16-bit partial-sum outputs on the rising edge of that flag.
- Optionally applies ReLU to each element, then serialises the L results over a valid/ready stream, one element per accepted beat.
- After the last beat, pulses a restart request so the controller can reset the array for the next tile.

---
 rtl/tpu_pkg.sv | 21 ++
 rtl/result_drain_if.sv | 33 +++
 rtl/result_drain.sv | 101 ++++++++++
 tb/tb_result_drain.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: element width, drain FSM states and
// activation helpers reused by downstream stages.
package tpu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    STREAM,
    RELEASE
  } drain_state_t;

  function automatic logic [DATA_W-1:0] relu16(
    input logic [DATA_W-1:0] x,
    input logic              en
  );
    return (en && x[DATA_W-1]) ? '0 : x;
  endfunction

endpackage

// File: rtl/result_drain_if.sv
// Result stream from the drain: one element per accepted beat,
// tagged with its index and a last marker.
interface result_drain_if
  import tpu_pkg::*;
#(
  parameter int L = 32
);

  localparam int IW = $clog2(L);

  logic [DATA_W-1:0] out_data;
  logic [IW-1:0]     out_idx;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/result_drain.sv
// Snapshots the systolic array outputs on the completion edge,
// streams them out one per beat, then requests an array restart.
module result_drain
  import tpu_pkg::*;
#(
  parameter int L = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arr_ready,
  input  logic [DATA_W-1:0] arr_p [L],
  input  logic              act_relu,
  result_drain_if.master    s,
  output logic              arr_restart,
  output logic              busy,
  output logic              overrun
);

  localparam int IW = $clog2(L);
  localparam logic [IW-1:0] LAST = IW'(L - 1);

  drain_state_t      state;
  logic              rdy_q;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] mem [L];
  logic              valid_q;
  logic              last_q;
  logic              cap_evt;
  logic              accept;
  logic [IW-1:0]     idx_nxt;

  assign cap_evt = arr_ready & ~rdy_q;
  assign accept  = valid_q & s.out_ready;
  assign idx_nxt = idx + IW'(1);

  // idx is a flop, so data/index are driven straight from state
  assign s.out_valid = valid_q;
  assign s.out_last  = last_q;
  assign s.out_idx   = idx;
  assign s.out_data  = valid_q ? mem[idx] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rdy_q       <= 1'b0;
      idx         <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      arr_restart <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < L; i++) begin
        mem[i] <= '0;
      end
    end else begin
      rdy_q       <= arr_ready;
      arr_restart <= 1'b0;
      if (cap_evt && state != IDLE) begin
        overrun <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (cap_evt) begin
            for (int i = 0; i < L; i++) begin
              mem[i] <= relu16(arr_p[i], act_relu);
            end
            idx   <= '0;
            busy  <= 1'b1;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          idx     <= '0;
          valid_q <= 1'b1;
          last_q  <= 1'b0;
          state   <= STREAM;
        end
        STREAM: begin
          if (accept) begin
            if (idx == LAST) begin
              idx         <= '0;
              valid_q     <= 1'b0;
              last_q      <= 1'b0;
              arr_restart <= 1'b1;
              state       <= RELEASE;
            end else begin
              idx    <= idx_nxt;
              last_q <= (idx_nxt == LAST);
            end
          end
        end
        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain with a queue-based reference
// model checked every cycle plus literal spot checks.
module tb_result_drain;

  localparam int L = 4;
  localparam int IW = $clog2(L);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arr_ready = 1'b0;
  logic [15:0] arr_p [L];
  logic        act_relu = 1'b0;
  logic        arr_restart;
  logic        busy;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int rst_cnt = 0;

  logic [31:0] log_q [$];

  result_drain_if #(.L(L)) bus ();

  result_drain #(.L(L)) dut (
    .clk        (clk),
    .reset      (reset),
    .arr_ready  (arr_ready),
    .arr_p      (arr_p),
    .act_relu   (act_relu),
    .s          (bus.master),
    .arr_restart(arr_restart),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: phase 0 idle, 1 bubble, 2 streaming, 3 restart.
  int          m_phase = 0;
  int          m_taken = 0;
  logic        m_prev = 1'b0;
  logic        m_ovr = 1'b0;
  logic [15:0] m_q [$];

  always @(posedge clk or posedge reset) begin
    logic evt;
    if (reset) begin
      m_phase = 0;
      m_taken = 0;
      m_prev  = 1'b0;
      m_ovr   = 1'b0;
      m_q.delete();
    end else begin
      evt    = arr_ready && !m_prev;
      m_prev = arr_ready;
      if (evt && m_phase != 0) m_ovr = 1'b1;
      case (m_phase)
        0: if (evt) begin
          for (int i = 0; i < L; i++) begin
            m_q.push_back((act_relu && arr_p[i][15]) ? 16'h0 : arr_p[i]);
          end
          m_taken = 0;
          m_phase = 1;
        end
        1: m_phase = 2;
        2: if (bus.out_ready) begin
          void'(m_q.pop_front());
          m_taken++;
          if (m_taken == L) begin
            m_taken = 0;
            m_phase = 3;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("valid", bus.out_valid, m_phase == 2);
      chk("data", bus.out_data, (m_phase == 2) ? m_q[0] : 16'h0);
      chk("idx", bus.out_idx, m_taken);
      chk("last", bus.out_last, m_phase == 2 && m_taken == L - 1);
      chk("restart", arr_restart, m_phase == 3);
      chk("busy", busy, m_phase != 0);
      chk("overrun", overrun, m_ovr);
    end
  end

  always @(posedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready)
      log_q.push_back({14'h0, 2'(bus.out_idx), bus.out_data});
    if (!reset && arr_restart) rst_cnt++;
  end

  task automatic set_vec();
    arr_p[0] = 16'h0001;
    arr_p[1] = 16'hFFFE;
    arr_p[2] = 16'h7FFF;
    arr_p[3] = 16'h8000;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (arr_restart) seen = 1;
    end
    chk("done_timeout", seen, 1'b1);
    @(negedge clk);
  endtask

  task automatic check_log(input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] e [L];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk("log_len", log_q.size(), L);
    for (int i = 0; i < L && i < log_q.size(); i++) begin
      chk("log_idx", log_q[i][31:16], i);
      chk("log_data", log_q[i][15:0], e[i]);
    end
  endtask

  task automatic rearm();
    @(negedge clk);
    arr_ready = 1'b0;
    @(negedge clk);
    log_q.delete();
    arr_ready = 1'b1;
  endtask

  initial begin
    int n;
    bit hit;
    set_vec();
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_data", bus.out_data, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_restart", arr_restart, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // basic drain and latency
    log_q.delete();
    arr_ready = 1'b1;
    @(negedge clk);
    chk("cap_valid", bus.out_valid, 1'b0);
    chk("cap_busy", busy, 1'b1);
    @(negedge clk);
    chk("first_valid", bus.out_valid, 1'b1);
    chk("first_data", bus.out_data, 16'h0001);
    n = 1;
    while (!arr_restart && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("restart_lat", n, L + 1);
    @(negedge clk);
    chk("restart_pulse", arr_restart, 1'b0);
    check_log(16'h0001, 16'hFFFE, 16'h7FFF, 16'h8000);

    // sticky arr_ready: no re-capture
    repeat (8) @(negedge clk);
    chk("sticky_busy", busy, 1'b0);
    chk("sticky_beats", log_q.size(), L);

    // relu, and act_relu changed mid-stream
    act_relu = 1'b1;
    rearm();
    @(negedge clk);
    act_relu = 1'b0;
    wait_done();
    check_log(16'h0001, 16'h0000, 16'h7FFF, 16'h0000);

    // backpressure at idx1 plus input isolation
    rearm();
    @(negedge clk);
    for (int i = 0; i < L; i++) arr_p[i] = 16'h1234;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (bus.out_valid && bus.out_idx == 1) hit = 1;
      else @(negedge clk);
    end
    chk("bp_reach", hit, 1'b1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_data", bus.out_data, 16'hFFFE);
      chk("bp_idx", bus.out_idx, 1);
    end
    bus.out_ready = 1'b1;
    wait_done();
    check_log(16'h0001, 16'hFFFE, 16'h7FFF, 16'h8000);
    set_vec();
    chk("ovr_pre", overrun, 1'b0);

    // overrun: completion edge during stream
    rearm();
    repeat (2) @(negedge clk);
    arr_ready = 1'b0;
    @(negedge clk);
    arr_ready = 1'b1;
    wait_done();
    check_log(16'h0001, 16'hFFFE, 16'h7FFF, 16'h8000);
    repeat (4) @(negedge clk);
    chk("ovr_sticky", overrun, 1'b1);

    // reset mid-stream after idx1 accepted
    rearm();
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_idx == 2) hit = 1;
    end
    chk("rs_reach", hit, 1'b1);
    n = rst_cnt;
    #1 reset = 1'b1;
    #1;
    chk("rs_valid", bus.out_valid, 1'b0);
    chk("rs_idx", bus.out_idx, 0);
    chk("rs_busy", busy, 1'b0);
    chk("rs_ovr", overrun, 1'b0);
    chk("rs_restart", arr_restart, 1'b0);
    repeat (2) @(negedge clk);
    chk("rs_no_pulse", rst_cnt, n);
    log_q.delete();
    reset = 1'b0;
    wait_done();
    chk("rs_one_pulse", rst_cnt, n + 1);
    check_log(16'h0001, 16'hFFFE, 16'h7FFF, 16'h8000);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
